// File: rtl/hall_sensor_conditioner.sv
// Hall sensor conditioner: synchronises and glitch-filters the three raw hall
// lines, rejects illegal patterns, tracks rotation direction, and measures the
// clock count between accepted hall edges with stall detection.
module hall_sensor_conditioner #(
   parameter int unsigned         SYNC_STAGES  = 2,
   parameter int unsigned         FILT_CYCLES  = 16,
   parameter int unsigned         PERIOD_W     = 24,
   parameter logic [PERIOD_W-1:0] STALL_CYCLES = 24'd5000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [2:0]          hs_raw,
   output logic [2:0]          hs_out,
   output logic                hs_valid,
   output logic                edge_pulse,
   output logic                dir_cw,
   output logic                hall_fault,
   output logic [PERIOD_W-1:0] period,
   output logic                period_valid,
   output logic                stalled
);

   localparam int unsigned    FCW      = $clog2(FILT_CYCLES + 1);
   localparam logic [FCW-1:0] FILT_MAX = FCW'(FILT_CYCLES);

   // Clockwise successor of a legal hall state; illegal states map to 000.
   function automatic logic [2:0] cw_next(input logic [2:0] s);
      case (s)
         3'b001:  cw_next = 3'b011;
         3'b011:  cw_next = 3'b010;
         3'b010:  cw_next = 3'b110;
         3'b110:  cw_next = 3'b100;
         3'b100:  cw_next = 3'b101;
         3'b101:  cw_next = 3'b001;
         default: cw_next = 3'b000;
      endcase
   endfunction

   logic [SYNC_STAGES-1:0][2:0] sync_q;
   logic [2:0]                  hs_sync;

   logic [2:0]    cand_q, cand_d;
   logic [FCW-1:0] fcnt_q, fcnt_d;
   logic          accept;
   logic          legal;
   logic          hall_ev;

   logic [2:0]    hs_q, hs_d;
   logic          valid_q, valid_d;
   logic          edge_q, edge_d;
   logic          dir_q, dir_d;
   logic          fault_q, fault_d;

   logic [PERIOD_W-1:0] tcnt_q, tcnt_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                pv_q, pv_d;
   logic                armed_q, armed_d;
   logic                stall_q, stall_d;

   assign hs_sync = sync_q[SYNC_STAGES-1];

   // Plain flop chain per hall line; nothing combinational before the last stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], hs_raw};
      end
   end

   // Candidate/counter filter: a new value restarts the count, a held value saturates it.
   always_comb begin
      cand_d = cand_q;
      fcnt_d = fcnt_q;
      if (hs_sync != cand_q) begin
         cand_d = hs_sync;
         fcnt_d = FCW'(1);
      end else if (fcnt_q != FILT_MAX) begin
         fcnt_d = fcnt_q + FCW'(1);
      end
   end

   // Candidate is accepted once it has been seen for FILT_CYCLES consecutive clocks.
   assign accept  = (fcnt_q == FILT_MAX);
   assign legal   = (cand_q != 3'b000) && (cand_q != 3'b111);
   assign hall_ev = accept && legal && (cand_q != hs_q);

   // Legality, direction and fault tracking for accepted patterns.
   always_comb begin
      hs_d    = hs_q;
      valid_d = valid_q;
      edge_d  = hall_ev;
      dir_d   = dir_q;
      fault_d = fault_q;
      if (accept && !legal) begin
         fault_d = 1'b1;
      end else if (hall_ev) begin
         hs_d    = cand_q;
         valid_d = 1'b1;
         if (valid_q) begin
            if (cand_q == cw_next(hs_q)) begin
               dir_d   = 1'b1;
               fault_d = 1'b0;
            end else if (cw_next(cand_q) == hs_q) begin
               dir_d   = 1'b0;
               fault_d = 1'b0;
            end else begin
               fault_d = 1'b1;
            end
         end
      end
   end

   // Edge-to-edge timer; an edge in the saturating cycle wins over the stall.
   always_comb begin
      tcnt_d   = (tcnt_q == STALL_CYCLES) ? tcnt_q : tcnt_q + PERIOD_W'(1);
      period_d = period_q;
      pv_d     = pv_q;
      armed_d  = armed_q;
      stall_d  = stall_q;
      if (hall_ev) begin
         tcnt_d  = PERIOD_W'(1);
         stall_d = 1'b0;
         if (armed_q) begin
            period_d = tcnt_q;
            pv_d     = 1'b1;
         end else begin
            armed_d = 1'b1;
         end
      end else if (tcnt_q == STALL_CYCLES) begin
         stall_d = 1'b1;
         pv_d    = 1'b0;
         armed_d = 1'b0;
      end
   end

   // State registers for filter, hall state and timer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_q   <= '0;
         fcnt_q   <= '0;
         hs_q     <= '0;
         valid_q  <= 1'b0;
         edge_q   <= 1'b0;
         dir_q    <= 1'b0;
         fault_q  <= 1'b0;
         tcnt_q   <= '0;
         period_q <= '0;
         pv_q     <= 1'b0;
         armed_q  <= 1'b0;
         stall_q  <= 1'b0;
      end else begin
         cand_q   <= cand_d;
         fcnt_q   <= fcnt_d;
         hs_q     <= hs_d;
         valid_q  <= valid_d;
         edge_q   <= edge_d;
         dir_q    <= dir_d;
         fault_q  <= fault_d;
         tcnt_q   <= tcnt_d;
         period_q <= period_d;
         pv_q     <= pv_d;
         armed_q  <= armed_d;
         stall_q  <= stall_d;
      end
   end

   assign hs_out       = hs_q;
   assign hs_valid     = valid_q;
   assign edge_pulse   = edge_q;
   assign dir_cw       = dir_q;
   assign hall_fault   = fault_q;
   assign period       = period_q;
   assign period_valid = pv_q;
   assign stalled      = stall_q;

endmodule

// File: tb/tb_hall_sensor_conditioner.sv
// Testbench for hall_sensor_conditioner: directed table, hand-written corner
// sequences and randomized stimulus checked against a behavioural model.
module tb_hall_sensor_conditioner;

   localparam int unsigned PW    = 24;
   localparam int unsigned FILT  = 16;
   localparam int unsigned STALL = 1000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [2:0]    hs_raw;
   logic [2:0]    hs_out;
   logic          hs_valid;
   logic          edge_pulse;
   logic          dir_cw;
   logic          hall_fault;
   logic [PW-1:0] period;
   logic          period_valid;
   logic          stalled;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hall_sensor_conditioner #(
      .SYNC_STAGES (2),
      .FILT_CYCLES (16),
      .PERIOD_W    (24),
      .STALL_CYCLES(24'd1000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .hs_raw      (hs_raw),
      .hs_out      (hs_out),
      .hs_valid    (hs_valid),
      .edge_pulse  (edge_pulse),
      .dir_cw      (dir_cw),
      .hall_fault  (hall_fault),
      .period      (period),
      .period_valid(period_valid),
      .stalled     (stalled)
   );

   // Clockwise order of the legal hall states.
   logic [2:0] cw_ord [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

   function automatic int pos(input logic [2:0] v);
      for (int i = 0; i < 6; i++) if (cw_ord[i] == v) return i;
      return -1;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [2:0]  m_pipe [2];
   logic [2:0]  m_win [$];
   logic [2:0]  m_hs;
   bit          m_valid, m_edge, m_dir, m_fault, m_pv, m_stalled, m_armed;
   int unsigned m_period, m_n, m_ref;

   task automatic model_reset();
      m_pipe[0] = '0; m_pipe[1] = '0;
      m_win.delete();
      m_hs = '0; m_valid = 0; m_edge = 0; m_dir = 0; m_fault = 0;
      m_pv = 0; m_stalled = 0; m_armed = 0;
      m_period = 0; m_n = 0; m_ref = 0;
   endtask

   // Advance the model by one clock edge that samples raw value r.
   task automatic model_edge(input logic [2:0] r);
      logic [2:0]  s, v;
      bit          acc, ev;
      int unsigned el;
      int          d;
      s   = m_pipe[1];
      v   = '0;
      acc = (m_win.size() == FILT);
      if (acc) begin
         v = m_win[0];
         foreach (m_win[i]) if (m_win[i] != v) acc = 0;
      end
      m_win.push_back(s);
      if (m_win.size() > FILT) void'(m_win.pop_front());
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = r;
      ev = 0;
      m_edge = 0;
      if (acc) begin
         if (v == 3'b000 || v == 3'b111) begin
            m_fault = 1;
         end else if (v != m_hs) begin
            ev = 1;
            if (m_valid) begin
               d = (pos(v) - pos(m_hs) + 6) % 6;
               if (d == 1) begin m_dir = 1; m_fault = 0; end
               else if (d == 5) begin m_dir = 0; m_fault = 0; end
               else m_fault = 1;
            end
            m_hs = v; m_valid = 1; m_edge = 1;
         end
      end
      el = m_n - m_ref;
      if (el > STALL) el = STALL;
      if (ev) begin
         if (m_armed) begin m_period = el; m_pv = 1; end
         else m_armed = 1;
         m_stalled = 0;
         m_ref = m_n;
      end else if (el == STALL) begin
         m_stalled = 1; m_pv = 0; m_armed = 0;
      end
      m_n++;
   endtask

   function automatic logic [63:0] dut_vec();
      return 64'({hs_out, hs_valid, edge_pulse, dir_cw, hall_fault, period, period_valid, stalled});
   endfunction

   function automatic logic [63:0] mdl_vec();
      logic [PW-1:0] p;
      p = m_period[PW-1:0];
      return 64'({m_hs, m_valid, m_edge, m_dir, m_fault, p, m_pv, m_stalled});
   endfunction

   // One clock: drive r, let the edge sample it, compare DUT with the model.
   task automatic step(input logic [2:0] r);
      hs_raw = r;
      @(posedge clk);
      model_edge(r);
      #1;
      chk("model", dut_vec(), mdl_vec());
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_hs_out"},   64'(hs_out),       64'(0));
      chk({tag, "_hs_valid"}, 64'(hs_valid),     64'(0));
      chk({tag, "_edge"},     64'(edge_pulse),   64'(0));
      chk({tag, "_dir"},      64'(dir_cw),       64'(0));
      chk({tag, "_fault"},    64'(hall_fault),   64'(0));
      chk({tag, "_period"},   64'(period),       64'(0));
      chk({tag, "_pv"},       64'(period_valid), 64'(0));
      chk({tag, "_stalled"},  64'(stalled),      64'(0));
   endtask

   task automatic do_reset(input logic [2:0] r);
      hs_raw = r;
      rst_n  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      model_reset();
      rst_n = 1'b1;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [2:0]  raw;
      int unsigned hold;
      logic [2:0]  hs;
      bit          dir;
      bit          fault;
      bit          pv;
      int unsigned per;
      int unsigned edges;
   } vec_t;

   vec_t tbl [$];

   task automatic add(input logic [2:0] raw, input logic [2:0] hs, input bit dir,
                      input bit fault, input bit pv, input int unsigned per,
                      input int unsigned edges);
      vec_t v;
      v = '{raw, 100, hs, dir, fault, pv, per, edges};
      tbl.push_back(v);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          flag, saw;
      int          e_idx, s_idx, nedge;
      logic [2:0]  cur, r;
      int unsigned k, hold;

      // Table: reset start, CW run, CCW run, illegal holds, skips.
      add(3'b001, 3'b001, 0, 0, 0, 0,   1);
      add(3'b011, 3'b011, 1, 0, 1, 100, 1);
      add(3'b010, 3'b010, 1, 0, 1, 100, 1);
      add(3'b110, 3'b110, 1, 0, 1, 100, 1);
      add(3'b100, 3'b100, 1, 0, 1, 100, 1);
      add(3'b101, 3'b101, 1, 0, 1, 100, 1);
      add(3'b001, 3'b001, 1, 0, 1, 100, 1);
      add(3'b101, 3'b101, 0, 0, 1, 100, 1);
      add(3'b100, 3'b100, 0, 0, 1, 100, 1);
      add(3'b110, 3'b110, 0, 0, 1, 100, 1);
      add(3'b010, 3'b010, 0, 0, 1, 100, 1);
      add(3'b011, 3'b011, 0, 0, 1, 100, 1);
      add(3'b001, 3'b001, 0, 0, 1, 100, 1);
      add(3'b111, 3'b001, 0, 1, 1, 100, 0);
      add(3'b011, 3'b011, 1, 0, 1, 200, 1);
      add(3'b110, 3'b110, 1, 1, 1, 100, 1);
      add(3'b100, 3'b100, 1, 0, 1, 100, 1);
      add(3'b101, 3'b101, 1, 0, 1, 100, 1);
      add(3'b001, 3'b001, 1, 0, 1, 100, 1);
      add(3'b010, 3'b010, 1, 1, 1, 100, 1);
      add(3'b011, 3'b011, 0, 0, 1, 100, 1);
      add(3'b000, 3'b011, 0, 1, 1, 100, 0);
      add(3'b010, 3'b010, 1, 0, 1, 200, 1);

      // Reset state and first-state latency.
      do_reset(3'b001);
      flag = 0;
      for (int i = 0; i < 18; i++) begin
         step(3'b001);
         if (hs_out != 3'b000 || edge_pulse) flag = 1;
      end
      chk("latency_not_early", 64'(flag), 64'(0));
      step(3'b001);
      chk("latency_hs_out",   64'(hs_out),     64'(3'b001));
      chk("first_edge_pulse", 64'(edge_pulse), 64'(1));
      chk("first_valid",      64'(hs_valid),   64'(1));
      chk("first_dir",        64'(dir_cw),     64'(0));
      chk("first_fault",      64'(hall_fault), 64'(0));
      step(3'b001);
      chk("edge_one_clock",   64'(edge_pulse), 64'(0));

      // Short glitch must not reach the output.
      saw = 0; flag = 0;
      for (int i = 0; i < 10; i++) step(3'b001);
      for (int i = 0; i < 5; i++) begin step(3'b011); saw |= edge_pulse; end
      for (int i = 0; i < 30; i++) begin
         step(3'b001);
         saw |= edge_pulse;
         if (hs_out != 3'b001) flag = 1;
      end
      chk("glitch_no_edge", 64'(saw),  64'(0));
      chk("glitch_hs_held", 64'(flag), 64'(0));

      // Table-driven run from a fresh reset.
      do_reset(3'b001);
      for (int i = 0; i < tbl.size(); i++) begin
         nedge = 0;
         for (int unsigned c = 0; c < tbl[i].hold; c++) begin
            step(tbl[i].raw);
            if (edge_pulse) nedge++;
         end
         chk($sformatf("tbl%0d_hs", i),    64'(hs_out),       64'(tbl[i].hs));
         chk($sformatf("tbl%0d_valid", i), 64'(hs_valid),     64'(1));
         chk($sformatf("tbl%0d_dir", i),   64'(dir_cw),       64'(tbl[i].dir));
         chk($sformatf("tbl%0d_fault", i), 64'(hall_fault),   64'(tbl[i].fault));
         chk($sformatf("tbl%0d_pv", i),    64'(period_valid), 64'(tbl[i].pv));
         chk($sformatf("tbl%0d_per", i),   64'(period),       64'(tbl[i].per));
         chk($sformatf("tbl%0d_edges", i), 64'(nedge),        64'(tbl[i].edges));
      end

      // Stall: hold a state long after its edge.
      e_idx = -1; s_idx = -1;
      for (int i = 0; i < 1300; i++) begin
         step(3'b011);
         if (edge_pulse && e_idx < 0) e_idx = i;
         if (stalled && s_idx < 0) s_idx = i;
      end
      chk("stall_delay",   64'(s_idx - e_idx), 64'(STALL));
      chk("stall_flag",    64'(stalled),       64'(1));
      chk("stall_pv",      64'(period_valid),  64'(0));
      chk("stall_period",  64'(period),        64'(100));
      for (int i = 0; i < 100; i++) step(3'b001);
      chk("unstall_flag",   64'(stalled),      64'(0));
      chk("unstall_period", 64'(period),       64'(100));
      chk("unstall_pv",     64'(period_valid), 64'(0));
      for (int i = 0; i < 100; i++) step(3'b011);
      chk("restart_pv",     64'(period_valid), 64'(1));
      chk("restart_period", 64'(period),       64'(100));

      // Asynchronous reset mid-filter and mid-period, between clock edges.
      for (int i = 0; i < 5; i++) step(3'b010);
      #3;
      rst_n = 1'b0;
      #1;
      check_zero("async");
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;

      // Randomized segments against the model.
      cur = 3'b011;
      for (int seg = 0; seg < 250; seg++) begin
         k = $urandom_range(0, 99);
         if (k < 10) begin
            r = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000;
         end else if (k < 70) begin
            r = cw_ord[(pos(cur) + (($urandom_range(0, 1) == 1) ? 1 : 5)) % 6];
            cur = r;
         end else begin
            r = cw_ord[$urandom_range(0, 5)];
            cur = r;
         end
         hold = ((k % 4) == 0) ? $urandom_range(1, 15) : $urandom_range(16, 60);
         if ($urandom_range(0, 49) == 0) hold = 1100;
         for (int unsigned c = 0; c < hold; c++) step(r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
